seq_stage_controller: RTL
=========================

SEQ_STAGE_CONTROLLER -- requirements
Module: seq_stage_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port start, input, 1 bit: one-cycle pulse that begins execution from IDLE.
REQ-004 SHALL have port icode, input, 4 bits: opcode of the current instruction, valid from DECODE onward.
REQ-005 SHALL have port imem_req, output, 1 bit, and port imem_ack, input, 1 bit: fetch handshake.
REQ-006 SHALL have port imem_error, input, 1 bit, and port instr_valid, input, 1 bit: both sampled with imem_ack.
REQ-007 SHALL have port dmem_req, output, 1 bit, and port dmem_ack, input, 1 bit: data-memory handshake.
REQ-008 SHALL have port dmem_error, input, 1 bit: sampled with dmem_ack.
REQ-009 SHALL have ports dec_en, exe_en, wb_en and pc_we, outputs, 1 bit each: one-cycle stage strobes.
REQ-010 SHALL have port stat, output, 3 bits: Y86 status, encoded AOK=1, HLT=2, ADR=3, INS=4.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE, HALT and ERR.

Function
REQ-012 SHALL implement the states IDLE, FETCH, DECODE, EXECUTE, MEMORY, WRITEBACK, PCUPD, HALT and ERR.
REQ-013 IDLE -> FETCH on start; start SHALL be ignored in all other states.
REQ-014 FETCH SHALL hold imem_req high until imem_ack, with wait states unbounded; a cycle with imem_ack drops imem_req in the following cycle.
REQ-015 On imem_ack: imem_error=1 -> ERR with stat=ADR; else instr_valid=0 -> ERR with stat=INS; else -> DECODE. imem_error takes priority.
REQ-016 DECODE SHALL pulse dec_en for 1 cycle; icode=0 (halt) -> HALT with stat=HLT; else -> EXECUTE.
REQ-017 EXECUTE SHALL pulse exe_en for 1 cycle, then go to MEMORY if icode is 4, 5, 8, 9, 0xA or 0xB; otherwise to WRITEBACK.
REQ-018 MEMORY SHALL hold dmem_req until dmem_ack; on ack, dmem_error=1 -> ERR with stat=ADR; else -> WRITEBACK.
REQ-019 WRITEBACK SHALL pulse wb_en for 1 cycle -> PCUPD.
REQ-020 PCUPD SHALL pulse pc_we for 1 cycle -> FETCH, so the PC register loads the selected next PC exactly once per instruction.
REQ-021 Minimum instruction latency SHALL be 5 cycles without MEMORY and 6 with it, each with zero-wait acks.
REQ-022 Strobes (dec_en, exe_en, wb_en, pc_we, imem_req, dmem_req) SHALL be mutually exclusive and Moore-decoded from state.
REQ-023 An ack arriving while the matching req is low SHALL be ignored.
REQ-024 HALT and ERR SHALL be terminal; only rst_n leaves them; stat SHALL be held.
REQ-025 stat SHALL be AOK in all non-terminal states.
REQ-026 pc_we SHALL never assert in HALT or ERR or on the faulting instruction.

Reset
REQ-027 rst_n low SHALL immediately force state=IDLE, all strobes and reqs=0, busy=0, stat=AOK, including mid-handshake.
REQ-028 Deassertion of rst_n SHALL be the only exit from HALT or ERR.

Configuration
REQ-029 With RETIRE_CNT_EN defined, the block SHALL add output retired, 64 bits: reset to 0, incremented on each pc_we, wrapping from all-ones to 0.
REQ-030 Without RETIRE_CNT_EN, the retired port and the counter SHALL be absent and all other behaviour identical.

Structure
REQ-031 A shared package SHALL hold the state enum, the stat codes (AOK/HLT/ADR/INS) and the icode constants (IHALT=0 ... IPOPQ=0xB).
REQ-032 One sub-module, seq_mem_need, SHALL be a combinational icode -> needs-MEMORY decode.

Verification
REQ-033 icode=6 (OPq), zero-wait acks, start pulse -> dec_en, exe_en, wb_en and pc_we each pulse once, next imem_req in cycle 6.
REQ-034 icode=5 (mrmovq), dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, pc_we once, latency 9.
REQ-035 imem_ack with imem_error=1 and instr_valid=0 -> ERR, stat=3, no pc_we, busy=0.
REQ-036 icode=0 -> HALT, stat=2; a later start pulse has no effect.
REQ-037 rst_n low during MEMORY with dmem_req high -> dmem_req=0 at once, state IDLE, stat=1.
REQ-038 RETIRE_CNT_EN defined, 3 OPq instructions then halt -> retired=3.

Source files
------------

// File: rtl/seq_stage_controller_pkg.sv
// Shared types and constants for the Y86 sequential stage controller.
package seq_stage_controller_pkg;

  localparam int unsigned ICODE_W  = 4;
  localparam int unsigned STAT_W   = 3;
  localparam int unsigned RETIRE_W = 64;

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_FETCH     = 4'd1,
    S_DECODE    = 4'd2,
    S_EXECUTE   = 4'd3,
    S_MEMORY    = 4'd4,
    S_WRITEBACK = 4'd5,
    S_PCUPD     = 4'd6,
    S_HALT      = 4'd7,
    S_ERR       = 4'd8
  } state_e;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  localparam logic [ICODE_W-1:0] IHALT   = 4'h0;
  localparam logic [ICODE_W-1:0] INOP    = 4'h1;
  localparam logic [ICODE_W-1:0] IRRMOVQ = 4'h2;
  localparam logic [ICODE_W-1:0] IIRMOVQ = 4'h3;
  localparam logic [ICODE_W-1:0] IRMMOVQ = 4'h4;
  localparam logic [ICODE_W-1:0] IMRMOVQ = 4'h5;
  localparam logic [ICODE_W-1:0] IOPQ    = 4'h6;
  localparam logic [ICODE_W-1:0] IJXX    = 4'h7;
  localparam logic [ICODE_W-1:0] ICALL   = 4'h8;
  localparam logic [ICODE_W-1:0] IRET    = 4'h9;
  localparam logic [ICODE_W-1:0] IPUSHQ  = 4'hA;
  localparam logic [ICODE_W-1:0] IPOPQ   = 4'hB;

  // Busy covers every state that is part of executing an instruction.
  function automatic logic is_active(input state_e s);
    return !(s inside {S_IDLE, S_HALT, S_ERR});
  endfunction

endpackage

// File: rtl/seq_mem_need.sv
// Combinational decode: does this icode need the MEMORY stage.
module seq_mem_need
  import seq_stage_controller_pkg::*;
(
  input  logic [ICODE_W-1:0] icode_i,
  output logic               needs_mem_c
);

  always_comb begin
    needs_mem_c = 1'b0;
    case (icode_i)
      IRMMOVQ, IMRMOVQ, ICALL, IRET, IPUSHQ, IPOPQ: needs_mem_c = 1'b1;
      default:                                      needs_mem_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_stage_controller.sv
// Y86 sequential stage controller: fetch/decode/execute/memory/writeback/PC-update.
// Optional retired-instruction counter is enabled by defining RETIRE_CNT_EN.
module seq_stage_controller
  import seq_stage_controller_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ICODE_W-1:0]  icode,
  output logic                imem_req,
  input  logic                imem_ack,
  input  logic                imem_error,
  input  logic                instr_valid,
  output logic                dmem_req,
  input  logic                dmem_ack,
  input  logic                dmem_error,
  output logic                dec_en,
  output logic                exe_en,
  output logic                wb_en,
  output logic                pc_we,
  output logic [STAT_W-1:0]   stat,
  output logic                busy
`ifdef RETIRE_CNT_EN
  ,
  output logic [RETIRE_W-1:0] retired
`endif
);

  state_e              state_q, state_d;
  logic [STAT_W-1:0]   stat_q, stat_d;
  logic [ICODE_W-1:0]  icode_q, icode_d;
  logic                imem_req_q, imem_req_d;
  logic                dmem_req_q, dmem_req_d;
  logic                dec_en_q, dec_en_d;
  logic                exe_en_q, exe_en_d;
  logic                wb_en_q, wb_en_d;
  logic                pc_we_q, pc_we_d;
  logic                busy_q, busy_d;
  logic                needs_mem_c;

  seq_mem_need u_mem_need (
    .icode_i     (icode_q),
    .needs_mem_c (needs_mem_c)
  );

  // Next state; strobes are decoded from the next state so the registered
  // copies are a pure function of the current state.
  always_comb begin
    state_d = state_q;
    stat_d  = stat_q;
    icode_d = icode_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_FETCH;
      end
      S_FETCH: begin
        if (imem_ack && imem_req_q) begin
          if (imem_error) begin
            state_d = S_ERR;
            stat_d  = STAT_ADR;
          end else if (!instr_valid) begin
            state_d = S_ERR;
            stat_d  = STAT_INS;
          end else begin
            state_d = S_DECODE;
          end
        end
      end
      S_DECODE: begin
        icode_d = icode;
        if (icode == IHALT) begin
          state_d = S_HALT;
          stat_d  = STAT_HLT;
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: state_d = needs_mem_c ? S_MEMORY : S_WRITEBACK;
      S_MEMORY: begin
        if (dmem_ack && dmem_req_q) begin
          if (dmem_error) begin
            state_d = S_ERR;
            stat_d  = STAT_ADR;
          end else begin
            state_d = S_WRITEBACK;
          end
        end
      end
      S_WRITEBACK: state_d = S_PCUPD;
      S_PCUPD:     state_d = S_FETCH;
      S_HALT:      state_d = S_HALT;
      S_ERR:       state_d = S_ERR;
      default: begin
        state_d = S_IDLE;
        stat_d  = STAT_AOK;
      end
    endcase

    imem_req_d = (state_d == S_FETCH);
    dec_en_d   = (state_d == S_DECODE);
    exe_en_d   = (state_d == S_EXECUTE);
    dmem_req_d = (state_d == S_MEMORY);
    wb_en_d    = (state_d == S_WRITEBACK);
    pc_we_d    = (state_d == S_PCUPD);
    busy_d     = is_active(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      stat_q     <= STAT_AOK;
      icode_q    <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      dec_en_q   <= 1'b0;
      exe_en_q   <= 1'b0;
      wb_en_q    <= 1'b0;
      pc_we_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      icode_q    <= icode_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      dec_en_q   <= dec_en_d;
      exe_en_q   <= exe_en_d;
      wb_en_q    <= wb_en_d;
      pc_we_q    <= pc_we_d;
      busy_q     <= busy_d;
    end
  end

  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign dec_en   = dec_en_q;
  assign exe_en   = exe_en_q;
  assign wb_en    = wb_en_q;
  assign pc_we    = pc_we_q;
  assign stat     = stat_q;
  assign busy     = busy_q;

`ifdef RETIRE_CNT_EN
  logic [RETIRE_W-1:0] retired_q;

  // Counts PC updates; wraps naturally at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       retired_q <= '0;
    else if (pc_we_q) retired_q <= retired_q + RETIRE_W'(1);
  end

  assign retired = retired_q;
`endif

endmodule
